uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_receiver.sv | 135 +++++++++++++
 tb/tb_uart_receiver.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: frame states, bit-period helper, data width.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } rx_state_t;

  function automatic int calc_cycle(input int clk_fre, input int baud_rate);
    return (clk_fre * 1000000) / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) with a one-byte valid/ready output
// buffer, frame-error and overrun pulses.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FRE   = 27,
  parameter int BAUD_RATE = 115200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_pin,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_valid,
  input  logic                 rx_data_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CYCLE = calc_cycle(CLK_FRE, BAUD_RATE);
  localparam int CNT_W = (CYCLE > 2) ? $clog2(CYCLE) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CYCLE / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLE - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 rx_prev;
  rx_state_t            state;
  rx_state_t            state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bad;
  logic                 sample_pt;
  logic                 stop_good;
  logic                 stop_bad;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_pin),
    .q   (rx_s)
  );

  always_comb begin
    state_nxt = state;
    sample_pt = 1'b0;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      IDLE: begin
        if (rx_prev && !rx_s) state_nxt = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          sample_pt = 1'b1;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          sample_pt = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == IDX_LAST) state_nxt = PARITY;
`else
          if (bit_idx == IDX_LAST) state_nxt = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == BIT_LAST) begin
          sample_pt = 1'b1;
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == BIT_LAST) begin
          sample_pt = 1'b1;
          state_nxt = IDLE;
          stop_good = rx_s && !par_bad;
          stop_bad  = !stop_good;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rx_prev       <= 1'b1;
      cnt           <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      par_bad       <= 1'b0;
      rx_data       <= '0;
      rx_data_valid <= 1'b0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state     <= state_nxt;
      rx_prev   <= rx_s;
      frame_err <= stop_bad;
      overrun   <= stop_good && rx_data_valid && !rx_data_ready;

      if (state == IDLE || sample_pt) cnt <= '0;
      else                            cnt <= cnt + CNT_W'(1);

      if (state == START) begin
        bit_idx <= '0;
        par_bad <= 1'b0;
      end

      if (state == DATA && sample_pt) begin
        shift   <= {rx_s, shift[DATA_BITS-1:1]};
        bit_idx <= bit_idx + 3'd1;
      end

`ifdef UART_RX_PARITY_EN
      // Even parity: the parity bit equals the XOR of the data bits.
      if (state == PARITY && sample_pt) par_bad <= (rx_s != ^shift);
`endif

      // A completing byte may replace the buffered one only if it is being consumed now.
      if (stop_good && (!rx_data_valid || rx_data_ready)) begin
        rx_data       <= shift;
        rx_data_valid <= 1'b1;
      end else if (rx_data_valid && rx_data_ready) begin
        rx_data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frames plus random frames against a byte-level model.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int CYCLE = (27 * 1000000) / 115200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_pin = 1'b1;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready = 1'b0;
  logic       frame_err;
  logic       overrun;

  int n_checks = 0;
  int n_pass   = 0;

  // Observed events, gathered at the falling edge.
  logic [7:0] got_q[$];
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  int         valid_cycles = 0;
  logic       unstable = 1'b0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  // Byte-level reference model.
  logic [7:0] exp_q[$];
  int         exp_ferr = 0;
  int         exp_ovr = 0;
  logic       mdl_pending = 1'b0;
  logic [7:0] mdl_held = 8'h00;

  uart_receiver #(.CLK_FRE(27), .BAUD_RATE(115200)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_pin        (rx_pin),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .frame_err     (frame_err),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_data_valid) valid_cycles <= valid_cycles + 1;
    if (rx_data_valid && rx_data_ready) got_q.push_back(rx_data);
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    if (prev_hold && rx_data_valid && rx_data !== prev_data) unstable <= 1'b1;
    prev_hold <= rx_data_valid && !rx_data_ready;
    prev_data <= rx_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rx_pin = b;
    wait_clk(CYCLE);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    send_bit(stop_v);
  endtask

  task automatic model_frame(input logic [7:0] d, input logic good, input logic rdy);
    if (!good) exp_ferr++;
    else if (mdl_pending) exp_ovr++;
    else if (rdy) exp_q.push_back(d);
    else begin
      mdl_pending = 1'b1;
      mdl_held    = d;
    end
  endtask

  task automatic model_consume();
    if (mdl_pending) exp_q.push_back(mdl_held);
    mdl_pending = 1'b0;
  endtask

  task automatic check_bytes(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int v0;
    logic [7:0] d;
    logic good;

    wait_clk(5);
    rst = 1'b0;
    wait_clk(1);
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", rx_data_valid, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    wait_clk(20);

    rx_data_ready = 1'b1;
    v0 = valid_cycles;
    send_frame(8'h55, 1'b1, 1'b0);
    model_frame(8'h55, 1'b1, 1'b1);
    wait_clk(5);
    check_bytes("b55");
    check("b55_valid_cycles", valid_cycles - v0, 1);
    check("b55_ferr", ferr_cnt, exp_ferr);

    rx_data_ready = 1'b0;
    unstable = 1'b0;
    send_frame(8'hA3, 1'b1, 1'b0);
    model_frame(8'hA3, 1'b1, 1'b0);
    wait_clk(5000);
    check("a3_valid_held", rx_data_valid, 1'b1);
    check("a3_data", rx_data, 8'hA3);
    check("a3_stable", unstable, 1'b0);
    rx_data_ready = 1'b1;
    model_consume();
    wait_clk(1);
    check("a3_valid_drop", rx_data_valid, 1'b0);
    check_bytes("a3");

    v0 = valid_cycles;
    rx_pin = 1'b0;
    wait_clk(50);
    rx_pin = 1'b1;
    wait_clk(300);
    check("glitch_valid", valid_cycles - v0, 0);
    check("glitch_state", 32'(dut.state), 32'(IDLE));
    check("glitch_ferr", ferr_cnt, exp_ferr);

    v0 = valid_cycles;
    send_frame(8'h0F, 1'b0, 1'b0);
    model_frame(8'h0F, 1'b0, 1'b1);
    rx_pin = 1'b1;
    wait_clk(CYCLE);
    check("f0f_ferr", ferr_cnt, exp_ferr);
    check("f0f_valid", valid_cycles - v0, 0);

    rx_data_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    model_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    model_frame(8'h22, 1'b1, 1'b0);
    wait_clk(5);
    check("ovr_count", ovr_cnt, exp_ovr);
    check("ovr_data", rx_data, 8'h11);
    check("ovr_valid", rx_data_valid, 1'b1);
    rx_data_ready = 1'b1;
    model_consume();
    wait_clk(3);
    check_bytes("ovr");

    d = 8'hC6;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx_pin = d[4];
    wait_clk(CYCLE / 2);
    rst = 1'b1;
    rx_pin = 1'b1;
    wait_clk(3);
    check("midrst_valid", rx_data_valid, 1'b0);
    rst = 1'b0;
    wait_clk(3 * CYCLE);
    check("midrst_state", 32'(dut.state), 32'(IDLE));
    send_frame(8'hC6, 1'b1, 1'b0);
    model_frame(8'hC6, 1'b1, 1'b1);
    wait_clk(5);
    check_bytes("c6");
    check("c6_ferr", ferr_cnt, exp_ferr);
`ifdef UART_RX_PARITY_EN
    send_frame(8'hC6, 1'b1, 1'b1);
    model_frame(8'hC6, 1'b0, 1'b1);
    wait_clk(5);
    check("par_ferr", ferr_cnt, exp_ferr);
    check_bytes("par");
`endif

    for (int k = 0; k < 12; k++) begin
      d    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 3) != 0);
      send_frame(d, good, 1'b0);
      model_frame(d, good, 1'b1);
      rx_pin = 1'b1;
      wait_clk(5);
      check_bytes("rnd");
    end
    check("rnd_ferr", ferr_cnt, exp_ferr);
    check("final_ovr", ovr_cnt, exp_ovr);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
